cart_dma_ctrl: RTL and testbench

CART_DMA_CTRL -- requirements
Module: cart_dma_ctrl

---
 rtl/cart_dma_ctrl_if.sv | 30 +++
 rtl/cart_dma_ctrl.sv | 155 +++++++++++++++
 tb/tb_cart_dma_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cart_dma_ctrl_if.sv
// Bus bundle for cart_dma_ctrl: CPU bus, cartridge bus and OAM write port.
// slave is the DMA controller's view, master is the surrounding system's view.
interface cart_dma_ctrl_if;
   logic [15:0] cpu_addr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] CART_ADDR;
   logic        CART_RD;
   logic        CART_WR;
   logic [7:0]  CART_DATA_out;
   logic [7:0]  CART_DATA_in;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_we;
   logic        dma_active;

   modport slave (
      input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, CART_DATA_in,
      output cpu_rdata, CART_ADDR, CART_RD, CART_WR, CART_DATA_out,
      output oam_addr, oam_wdata, oam_we, dma_active
   );

   modport master (
      output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, CART_DATA_in,
      input  cpu_rdata, CART_ADDR, CART_RD, CART_WR, CART_DATA_out,
      input  oam_addr, oam_wdata, oam_we, dma_active
   );
endinterface

// File: rtl/cart_dma_ctrl.sv
// OAM DMA engine: copies DMA_LEN bytes from page src_hi of the cartridge bus into OAM.
// Build macro CART_DMA_CPU_BLOCK_EN locks the CPU out during a transfer instead of cycle stealing.
module cart_dma_ctrl #(
   parameter int DMA_LEN = 160,
   parameter int RD_LAT  = 1
) (
   input logic            clk,
   input logic            rst,
   cart_dma_ctrl_if.slave bus
);

   localparam logic [2:0]  IDLE  = 3'd0;
   localparam logic [2:0]  START = 3'd1;
   localparam logic [2:0]  READ  = 3'd2;
   localparam logic [2:0]  WAIT  = 3'd3;
   localparam logic [2:0]  WRITE = 3'd4;

   localparam logic [15:0] DMA_REG   = 16'hFF46;
   localparam logic [15:0] HRAM_BASE = 16'hFF80;
   localparam logic [8:0]  LEN_FULL  = 9'(DMA_LEN);
   // DMA_LEN=256 truncates to 0, so the transfer ends when idx wraps.
   localparam logic [7:0]  LEN_END   = LEN_FULL[7:0];
   localparam logic [1:0]  WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   logic [2:0] state;
   logic [2:0] state_nxt_s;
   logic [7:0] src_hi;
   logic [7:0] src_nxt_s;
   logic [7:0] idx;
   logic [7:0] idx_nxt_s;
   logic [7:0] idx_inc_s;
   logic [1:0] wait_cnt_r;
   logic [1:0] wait_nxt_s;
   logic       ff46_wr_s;
   logic       active_s;
   logic       steal_s;
   logic       locked_s;

   // Decode the DMA register write and who owns the bus this cycle.
   always_comb begin
      ff46_wr_s = bus.cpu_wr && (bus.cpu_addr == DMA_REG);
      active_s  = (state != IDLE);
      idx_inc_s = idx + 8'd1;
      if (bus.cpu_wdata > 8'hDF) begin
         src_nxt_s = bus.cpu_wdata - 8'h20;
      end else begin
         src_nxt_s = bus.cpu_wdata;
      end
`ifdef CART_DMA_CPU_BLOCK_EN
      steal_s  = 1'b0;
      locked_s = active_s && (bus.cpu_addr < HRAM_BASE) && !ff46_wr_s;
`else
      steal_s  = active_s && (bus.cpu_rd || bus.cpu_wr);
      locked_s = 1'b0;
`endif
   end

   // Next-state logic; a CPU-stolen cycle parks the FSM in READ so the byte is reissued.
   always_comb begin
      state_nxt_s = state;
      idx_nxt_s   = idx;
      wait_nxt_s  = wait_cnt_r;
      if (ff46_wr_s) begin
         state_nxt_s = START;
         idx_nxt_s   = 8'd0;
         wait_nxt_s  = 2'd0;
      end else if (steal_s) begin
         state_nxt_s = READ;
         wait_nxt_s  = 2'd0;
      end else begin
         case (state)
            IDLE:  state_nxt_s = IDLE;
            START: state_nxt_s = READ;
            READ: begin
               wait_nxt_s = 2'd0;
               if (RD_LAT == 1) begin
                  state_nxt_s = WRITE;
               end else begin
                  state_nxt_s = WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_r == WAIT_LAST) begin
                  state_nxt_s = WRITE;
               end else begin
                  wait_nxt_s = wait_cnt_r + 2'd1;
               end
            end
            WRITE: begin
               idx_nxt_s = idx_inc_s;
               if (idx_inc_s == LEN_END) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = READ;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State, counter and source page registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         idx        <= 8'd0;
         src_hi     <= 8'd0;
         wait_cnt_r <= 2'd0;
      end else begin
         state      <= state_nxt_s;
         idx        <= idx_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         if (ff46_wr_s) begin
            src_hi <= src_nxt_s;
         end else begin
            src_hi <= src_hi;
         end
      end
   end

   // Bus muxing: transparent when idle or when the CPU steals the cycle, DMA-driven otherwise.
   always_comb begin
      bus.dma_active    = active_s;
      bus.CART_ADDR     = bus.cpu_addr;
      bus.CART_RD       = bus.cpu_rd;
      bus.CART_WR       = bus.cpu_wr;
      bus.CART_DATA_out = bus.cpu_wdata;
      bus.cpu_rdata     = bus.CART_DATA_in;
      bus.oam_we        = 1'b0;
      bus.oam_addr      = 8'd0;
      bus.oam_wdata     = 8'd0;
      if (active_s && !steal_s) begin
         bus.CART_ADDR     = {src_hi, idx};
         bus.CART_RD       = (state == READ);
         bus.CART_WR       = 1'b0;
         bus.CART_DATA_out = 8'h00;
         if (locked_s) begin
            bus.cpu_rdata = 8'hFF;
         end else begin
            bus.cpu_rdata = bus.CART_DATA_in;
         end
         // A restart write on the final cycle of a byte must not commit the stale byte.
         if ((state == WRITE) && !ff46_wr_s) begin
            bus.oam_we    = 1'b1;
            bus.oam_addr  = idx;
            bus.oam_wdata = bus.CART_DATA_in;
         end else begin
            bus.oam_we    = 1'b0;
         end
      end else begin
         bus.oam_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_cart_dma_ctrl.sv
// Directed bench for cart_dma_ctrl: default instance (160 bytes, RD_LAT=1) plus a short
// RD_LAT=2 instance; a cartridge model and an OAM-write scoreboard produce expected values.
module tb_cart_dma_ctrl;

   localparam int LEN1 = 160;
   localparam int LEN2 = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cart_dma_ctrl_if bus1 ();
   cart_dma_ctrl_if bus2 ();

   cart_dma_ctrl #(.DMA_LEN(LEN1), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   cart_dma_ctrl #(.DMA_LEN(LEN2), .RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks = 0;
   int fails  = 0;
   int seen1  = 0;
   int seen2  = 0;
   logic [15:0] q1[$];
   logic [15:0] q2[$];

   // Cartridge contents: a fixed scramble of the address.
   function automatic logic [7:0] cart_f(input logic [15:0] a);
      return a[7:0] ^ {a[12:8], a[15:13]};
   endfunction

   // Cartridge read pipeline: data appears RD_LAT cycles after the address.
   logic [15:0] p1, p2a, p2b;
   always @(posedge clk) begin
      p1  <= bus1.CART_ADDR;
      p2a <= bus2.CART_ADDR;
      p2b <= p2a;
   end
   assign bus1.CART_DATA_in = cart_f(p1);
   assign bus2.CART_DATA_in = cart_f(p2b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mon_oam();
      logic [15:0] e;
      if (bus1.oam_we === 1'b1) begin
         seen1++;
         if (q1.size() == 0) begin
            chk("oam1_spurious_we", 32'(bus1.oam_we), 32'd0);
         end else begin
            e = q1.pop_front();
            chk("oam1_write", {16'h0000, bus1.oam_addr, bus1.oam_wdata}, {16'h0000, e});
         end
      end
      if (bus2.oam_we === 1'b1) begin
         seen2++;
         if (q2.size() == 0) begin
            chk("oam2_spurious_we", 32'(bus2.oam_we), 32'd0);
         end else begin
            e = q2.pop_front();
            chk("oam2_write", {16'h0000, bus2.oam_addr, bus2.oam_wdata}, {16'h0000, e});
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon_oam();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] src_of(input logic [7:0] page);
      return (page > 8'hDF) ? (page - 8'h20) : page;
   endfunction

   task automatic start1(input logic [7:0] page, input bit from_idle);
      logic [7:0] ib;
      bus1.cpu_addr  = 16'hFF46;
      bus1.cpu_wdata = page;
      bus1.cpu_wr    = 1'b1;
      for (int i = 0; i < LEN1; i++) begin
         ib = 8'(i);
         q1.push_back({ib, cart_f({src_of(page), ib})});
      end
      #1;
      if (from_idle) begin
         chk("ff46_pass_wr", 32'(bus1.CART_WR), 32'd1);
         chk("ff46_pass_addr", 32'(bus1.CART_ADDR), 32'h0000FF46);
         chk("ff46_pass_data", 32'(bus1.CART_DATA_out), 32'(page));
         chk("ff46_idle_active", 32'(bus1.dma_active), 32'd0);
      end
      tick();
      bus1.cpu_wr   = 1'b0;
      bus1.cpu_addr = 16'h0000;
   endtask

   task automatic run1(input string tag, input int exp_cycles);
      int cnt;
      cnt = 0;
      while (bus1.dma_active === 1'b1 && cnt < 2000) begin
         cnt++;
         tick();
      end
      chk(tag, cnt, exp_cycles);
      chk({tag, "_drained"}, q1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int g;
      int cnt2;
      int exp2;
      rst = 1'b0;
      bus1.cpu_addr = 16'h0000; bus1.cpu_rd = 1'b0; bus1.cpu_wr = 1'b0; bus1.cpu_wdata = 8'h00;
      bus2.cpu_addr = 16'h0000; bus2.cpu_rd = 1'b0; bus2.cpu_wr = 1'b0; bus2.cpu_wdata = 8'h00;
      tick();
      tick();
      chk("rst_active1", 32'(bus1.dma_active), 32'd0);
      chk("rst_we1", 32'(bus1.oam_we), 32'd0);
      chk("rst_oam_addr1", 32'(bus1.oam_addr), 32'd0);
      chk("rst_oam_wdata1", 32'(bus1.oam_wdata), 32'd0);
      chk("rst_active2", 32'(bus2.dma_active), 32'd0);
      rst = 1'b1;

      // Idle transparency, write then read.
      bus1.cpu_addr = 16'h2000; bus1.cpu_wdata = 8'h05; bus1.cpu_wr = 1'b1;
      #1;
      chk("idle_wr", 32'(bus1.CART_WR), 32'd1);
      chk("idle_wr_addr", 32'(bus1.CART_ADDR), 32'h00002000);
      chk("idle_wr_data", 32'(bus1.CART_DATA_out), 32'h05);
      chk("idle_wr_rd", 32'(bus1.CART_RD), 32'd0);
      tick();
      bus1.cpu_wr = 1'b0; bus1.cpu_rd = 1'b1; bus1.cpu_addr = 16'h4123;
      #1;
      chk("idle_rd", 32'(bus1.CART_RD), 32'd1);
      chk("idle_rd_addr", 32'(bus1.CART_ADDR), 32'h00004123);
      chk("idle_rdata", 32'(bus1.cpu_rdata), 32'(cart_f(p1)));
      tick();
      bus1.cpu_rd = 1'b0;

      // Full transfers from C0 and from the echo page FE (-> DE).
      start1(8'hC0, 1'b1);
      run1("c0_cycles", 321);
      start1(8'hFE, 1'b1);
      run1("fe_cycles", 321);

      // Restart from 80 when idx reaches 50.
      start1(8'hC0, 1'b1);
      base = seen1; g = 0;
      while ((seen1 - base) < 50 && g < 500) begin g++; tick(); end
      chk("restart_point", seen1 - base, 50);
      q1.delete();
      start1(8'h80, 1'b0);
      run1("restart_cycles", 321);

      // Reset at idx 10 abandons the transfer.
      start1(8'h12, 1'b1);
      base = seen1; g = 0;
      while ((seen1 - base) < 10 && g < 200) begin g++; tick(); end
      chk("rst_point", seen1 - base, 10);
      rst = 1'b0;
      tick();
      chk("rst_mid_active", 32'(bus1.dma_active), 32'd0);
      chk("rst_mid_we", 32'(bus1.oam_we), 32'd0);
      rst = 1'b1;
      q1.delete();
      base = seen1;
      repeat (20) tick();
      chk("rst_no_more_writes", seen1 - base, 0);
      bus1.cpu_rd = 1'b1; bus1.cpu_addr = 16'h0100;
      #1;
      chk("post_rst_rd_addr", 32'(bus1.CART_ADDR), 32'h00000100);
      chk("post_rst_rd", 32'(bus1.CART_RD), 32'd1);
      chk("post_rst_rdata", 32'(bus1.cpu_rdata), 32'(cart_f(p1)));
      tick();
      bus1.cpu_rd = 1'b0;

      // RD_LAT=2 instance: CPU access lands in the first WAIT cycle.
      bus2.cpu_addr = 16'hFF46; bus2.cpu_wdata = 8'hC0; bus2.cpu_wr = 1'b1;
      for (int i = 0; i < LEN2; i++) q2.push_back({8'(i), cart_f({8'hC0, 8'(i)})});
      #1;
      chk("d2_ff46_pass", 32'(bus2.CART_WR), 32'd1);
      tick();
      bus2.cpu_wr = 1'b0; bus2.cpu_addr = 16'h0000;
      cnt2 = 0;
      repeat (2) begin cnt2++; tick(); end
      cnt2++;
      bus2.cpu_addr = 16'h0150; bus2.cpu_rd = 1'b1;
      #1;
`ifdef CART_DMA_CPU_BLOCK_EN
      chk("blk_rdata", 32'(bus2.cpu_rdata), 32'h000000FF);
      chk("blk_dma_addr", 32'(bus2.CART_ADDR), 32'h0000C000);
      tick();
      bus2.cpu_rd = 1'b0;
      cnt2++;
      bus2.cpu_addr = 16'h2000; bus2.cpu_wdata = 8'h33; bus2.cpu_wr = 1'b1;
      #1;
      chk("blk_wr_dropped", 32'(bus2.CART_WR), 32'd0);
      chk("blk_dma_continues", 32'(bus2.oam_we), 32'd1);
      tick();
      bus2.cpu_wr = 1'b0; bus2.cpu_addr = 16'h0000;
      exp2 = 1 + LEN2 * 3;
`else
      chk("steal_addr", 32'(bus2.CART_ADDR), 32'h00000150);
      chk("steal_rd", 32'(bus2.CART_RD), 32'd1);
      chk("steal_rdata", 32'(bus2.cpu_rdata), 32'(cart_f(p2b)));
      tick();
      bus2.cpu_rd = 1'b0; bus2.cpu_addr = 16'h0000;
      exp2 = 1 + LEN2 * 3 + 2;
`endif
      while (bus2.dma_active === 1'b1 && cnt2 < 200) begin cnt2++; tick(); end
      chk("d2_cycles", cnt2, exp2);
      chk("d2_drained", q2.size(), 0);
      chk("d2_byte_count", seen2, LEN2);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
